// File: rtl/fp_normalizer.sv
// Iterative significand normalizer: shifts subnormal significands left (up to
// 8 bits per cycle) until bit 52 is set, adjusting the exponent accordingly.
module fp_normalizer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_s,
  input  logic [10:0] in_e,
  input  logic [52:0] in_f,
  input  logic        in_e_z,
  input  logic        in_e_inf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_s,
  output logic [12:0] out_e,
  output logic [52:0] out_f,
  output logic        out_zero,
  output logic        out_inf_nan
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        s_q, s_d;
  logic [12:0] e_q, e_d;
  logic [52:0] f_q, f_d;
  logic        zero_q, zero_d;
  logic        inf_q, inf_d;

  logic [2:0]  lz_n;
  logic        lz_found;
  logic        top_byte_zero;
  logic        in_f_zero;

  // Exponent-zero flag is carried for the upstream interface only; the shift
  // decision looks at the hidden bit directly.
  logic        unused_e_z;
  assign unused_e_z = in_e_z;

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = (state_q == DONE);
  assign top_byte_zero = (f_q[52:45] == 8'd0);
  assign in_f_zero     = (in_f == 53'd0);

  // Leading-zero count of the top byte; only meaningful when it is non-zero.
  always_comb begin
    lz_n     = 3'd0;
    lz_found = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (!lz_found && f_q[45+i]) begin
        lz_n     = 3'(7 - i);
        lz_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    e_d     = e_q;
    f_d     = f_q;
    zero_d  = zero_q;
    inf_d   = inf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d    = in_s;
          e_d    = {{2{in_e[10]}}, in_e};
          f_d    = in_f;
          inf_d  = in_e_inf;
          zero_d = in_f_zero && !in_e_inf;
          if (in_e_inf || in_f_zero || in_f[52]) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (top_byte_zero) begin
          f_d = f_q << 8;
          e_d = e_q - 13'd8;
        end else begin
          f_d     = f_q << lz_n;
          e_d     = e_q - {10'd0, lz_n};
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= 1'b0;
      e_q     <= 13'd0;
      f_q     <= 53'd0;
      zero_q  <= 1'b0;
      inf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      e_q     <= e_d;
      f_q     <= f_d;
      zero_q  <= zero_d;
      inf_q   <= inf_d;
    end
  end

  assign out_s       = s_q;
  assign out_e       = e_q;
  assign out_f       = f_q;
  assign out_zero    = zero_q;
  assign out_inf_nan = inf_q;

endmodule

// File: doc/fp_normalizer.md
# fp_normalizer

Iterative significand normalizer that consumes the unpacked exponent, sign and special-value flags from the operand unpacker, together with the significand. It left-shifts subnormal significands until the hidden-bit position (bit 52) is 1 and subtracts the shift distance from the exponent. Downstream FPU datapaths therefore only ever see normalized operands. Each operand moves through a valid/ready handshake. Each cycle shifts the significand by up to 8 bits.

## Interface
- No parameters; widths are fixed for the double-precision internal format.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  an operand is presented.
- in_ready  out  1  block can accept an operand; combinational decode of state == IDLE.
- in_s  in  1  sign.
- in_e  in  11  unbiased exponent, two's complement: double −1022..1023, single −126..127 sign-extended; subnormals arrive already at emin.
- in_f  in  53  significand with hidden bit at bit 52. Single operands are MSB-aligned at f[52:29], with f[28:0] = 0.
- in_e_z  in  1  exponent field was all zeros.
- in_e_inf  in  1  exponent field was all ones (inf/NaN).
- out_valid  out  1  result is held.
- out_ready  in  1  consumer accepts the result.
- out_s  out  1  sign, passed through.
- out_e  out  13  exponent after normalization, two's complement.
- out_f  out  53  normalized significand.
- out_zero  out  1  significand was zero.
- out_inf_nan  out  1  copy of in_e_inf.

## Operation
- States:
  - IDLE: wait for an operand.
  - SHIFT: shift in progress.
  - DONE: result held.
- IDLE, accept (in_valid && in_ready):
  - Register s, f, e_inf, and sign-extend(in_e) to 13 bits.
  - Go to DONE if in_e_inf = 1, in_f == 0, or in_f[52] = 1; otherwise go to SHIFT.
  - out_zero = (in_f == 0) && !in_e_inf.
- SHIFT, every cycle:
  - If f_r[52:45] == 0: f_r <<= 8 and e_r −= 8; stay in SHIFT.
  - Else: n = leading-zero count of f_r[52:45] (0..7); f_r <<= n and e_r −= n; go to DONE.
- DONE:
  - out_valid = 1.
  - When out_ready = 1: go to IDLE and clear out_valid on that edge.
- Inf/NaN and zero are never shifted; their exponent passes through unchanged.
- Arithmetic:
  - Shifts fill zeros at the LSB.
  - The exponent subtract is 13-bit two's complement. The minimum value is −1074, so overflow cannot occur.
- out_s, out_e, out_f, out_zero and out_inf_nan are driven from the working registers. They are stable for the whole DONE state.
- in_e_z is informational only: the decision to shift uses f[52], not e_z.

## Timing
- Reset (asynchronous, while rst_n = 0):
  - state = IDLE.
  - out_valid, out_s, out_e, out_f, out_zero, out_inf_nan = 0.
  - in_ready = 1.
- Reset mid-operation: the in-flight operand is discarded with no output produced. The first cycle after release is IDLE and ready.
- Only one operand is in flight at a time. in_ready = 0 in SHIFT and DONE.
- Latency, from the accept edge to the first cycle with out_valid = 1:
  - 1 cycle for normal, zero, and inf/NaN operands.
  - floor(k/8) + 2 cycles for a subnormal with k leading zeros (1 ≤ k ≤ 52). Worst case is k = 52: 8 cycles.
- Throughput: one operand per (latency + 1) cycles with out_ready held at 1. The IDLE cycle after the handshake is mandatory.
- Backpressure: with out_ready = 0, DONE holds indefinitely with all outputs frozen.
- in_valid while not ready is ignored; the upstream stage must hold the operand until accepted.

## Test plan
- Normal, double 1.0: in_e = 0, in_f = 53'h10000000000000 → out_f unchanged, out_e = 0, out_valid 1 cycle after accept, handshake completes, in_ready = 1 on the next cycle.
- Minimum subnormal, fp = 64'h0000000000000001: in_e = 11'h402 (−1022), in_f = 1 → out_f = 53'h10000000000000, out_e = 13'h1BCE (−1074), latency 8.
- Subnormal, fp = 64'h0008000000000000: in_f = 53'h08000000000000 → out_f = 53'h10000000000000, out_e = 13'h1C01 (−1023), latency 2.
- Zero and inf, each checked separately:
  - +0: in_f = 0, in_e = −1022 → out_zero = 1, out_e = 13'h1C02 (−1022), latency 1.
  - +inf: in_e_inf = 1 → out_inf_nan = 1, out_f unchanged, latency 1.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE while in_valid = 1 with a new operand → outputs stable, in_ready = 0, new operand not accepted until after the handshake plus the IDLE cycle.
- Reset mid-SHIFT: drop rst_n during the 3rd SHIFT cycle of the minimum-subnormal case → all outputs 0 immediately. After release: IDLE, in_ready = 1, no out_valid pulse.
